// File: rtl/reg_file_mp_pkg.sv
// Shared CPU constants used to size the register file.
//   CPU_DATA_WIDTH : architectural register width in bits
//   CPU_ADDR_WIDTH : register index width (2**CPU_ADDR_WIDTH registers)
package reg_file_mp_pkg;

    localparam int CPU_DATA_WIDTH = 32;
    localparam int CPU_ADDR_WIDTH = 5;

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// reg_scoreboard: one busy bit per register, marking a pending producer.
//   clk, rst            : clock, synchronous active-high reset (clears all bits)
//   set_en, set_addr    : mark a register busy on the next edge
//   clr0_en, clr0_addr  : write port 0 completing; clears its target
//   clr1_en, clr1_addr  : write port 1 completing; clears its target
//   busy                : registered busy vector; bit 0 is always 0
module reg_scoreboard
    import reg_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int REG_NUM    = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clr0_en,
    input  logic [ADDR_WIDTH-1:0] clr0_addr,
    input  logic                  clr1_en,
    input  logic [ADDR_WIDTH-1:0] clr1_addr,
    output logic [REG_NUM-1:0]    busy
);

    logic [REG_NUM-1:0] busy_nxt;

    always_comb begin
        busy_nxt = busy;
        for (int i = 1; i < REG_NUM; i++) begin
            // A set in the same cycle as a clear belongs to a newer producer,
            // so it must win over the completing write.
            if (set_en && set_addr == ADDR_WIDTH'(i)) begin
                busy_nxt[i] = 1'b1;
            end else if ((clr0_en && clr0_addr == ADDR_WIDTH'(i)) ||
                         (clr1_en && clr1_addr == ADDR_WIDTH'(i))) begin
                busy_nxt[i] = 1'b0;
            end
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with same-cycle write bypass and
// a busy scoreboard for operand readiness.
//   clk, rst              : clock, synchronous active-high reset
//   wen0/waddr0/wdata0    : write port 0
//   wen1/waddr1/wdata1    : write port 1 (wins on an address collision)
//   raddr                 : NUM_RD packed read addresses, port k at [k*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata                 : NUM_RD packed read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rready                : per read port, operand available this cycle
//   bset_en, bset_addr    : mark a register busy (pending producer)
//   busy                  : scoreboard bits, one per register
//   gpr_flat              : registered architectural state, register i at [i*DATA_WIDTH +: DATA_WIDTH]
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = CPU_DATA_WIDTH,
    parameter int ADDR_WIDTH = CPU_ADDR_WIDTH,
    parameter int NUM_RD     = 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               wen0,
    input  logic                               wen1,
    input  logic [ADDR_WIDTH-1:0]              waddr0,
    input  logic [ADDR_WIDTH-1:0]              waddr1,
    input  logic [DATA_WIDTH-1:0]              wdata0,
    input  logic [DATA_WIDTH-1:0]              wdata1,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]       raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]       rdata,
    output logic [NUM_RD-1:0]                  rready,
    input  logic                               bset_en,
    input  logic [ADDR_WIDTH-1:0]              bset_addr,
    output logic [(1<<ADDR_WIDTH)-1:0]         busy,
    output logic [(1<<ADDR_WIDTH)*DATA_WIDTH-1:0] gpr_flat
);

    localparam int REG_NUM = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [REG_NUM];

    // Port 1 is written after port 0 so it takes the register on a collision.
    // Register 0 is never written, so it holds the zero it was reset to.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wen0 && waddr0 != '0) begin
                regs[waddr0] <= wdata0;
            end
            if (wen1 && waddr1 != '0) begin
                regs[waddr1] <= wdata1;
            end
        end
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_NUM    (REG_NUM)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .set_en    (bset_en),
        .set_addr  (bset_addr),
        .clr0_en   (wen0),
        .clr0_addr (waddr0),
        .clr1_en   (wen1),
        .clr1_addr (waddr1),
        .busy      (busy)
    );

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  hit0;
        logic                  hit1;

        assign addr = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit0 = wen0 && (waddr0 == addr) && (addr != '0);
        assign hit1 = wen1 && (waddr1 == addr) && (addr != '0);

        // Bypass is purely combinational and stays active during reset:
        // state only changes at the edge.
        assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = (addr == '0) ? '0     :
                                                   hit1         ? wdata1 :
                                                   hit0         ? wdata0 :
                                                                  regs[addr];

        // A busy operand is still ready if its producer is writing it now.
        assign rready[k] = (addr == '0) || hit0 || hit1 || !busy[addr];
    end

    for (genvar i = 0; i < REG_NUM; i++) begin : g_gpr
        if (i == 0) begin : g_zero
            assign gpr_flat[0 +: DATA_WIDTH] = '0;
        end else begin : g_reg
            assign gpr_flat[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (NUM_RD=4): directed vector table,
// hand-written corner sequences, then randomized traffic against an
// array-based reference model.
module tb_reg_file_mp;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 4;
    localparam int RN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              wen0, wen1;
    logic [AW-1:0]     waddr0, waddr1;
    logic [DW-1:0]     wdata0, wdata1;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rready;
    logic              bset_en;
    logic [AW-1:0]     bset_addr;
    logic [RN-1:0]     busy;
    logic [RN*DW-1:0]  gpr_flat;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_RD     (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen0      (wen0),
        .wen1      (wen1),
        .waddr0    (waddr0),
        .waddr1    (waddr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .raddr     (raddr),
        .rdata     (rdata),
        .rready    (rready),
        .bset_en   (bset_en),
        .bset_addr (bset_addr),
        .busy      (busy),
        .gpr_flat  (gpr_flat)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural registers and pending-producer flags.
    logic [DW-1:0] m_mem [RN];
    logic [RN-1:0] m_busy;

    typedef struct {
        bit        rst;
        bit        w0;
        bit [4:0]  a0;
        bit [31:0] d0;
        bit        w1;
        bit [4:0]  a1;
        bit [31:0] d1;
        bit        bs;
        bit [4:0]  ba;
        bit [4:0]  ra;
        bit [31:0] exp_rd;
        bit        exp_rr;
        bit [4:0]  ga;
        bit [31:0] exp_g;
        bit [4:0]  bb;
        bit        exp_b;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(bit r, bit w0, bit [4:0] a0, bit [31:0] d0,
                               bit w1, bit [4:0] a1, bit [31:0] d1,
                               bit bs, bit [4:0] ba, bit [4:0] ra,
                               bit [31:0] erd, bit err, bit [4:0] ga,
                               bit [31:0] eg, bit [4:0] bb, bit eb);
        vec_t t;
        t.rst = r;  t.w0 = w0; t.a0 = a0; t.d0 = d0;
        t.w1 = w1;  t.a1 = a1; t.d1 = d1;
        t.bs = bs;  t.ba = ba; t.ra = ra;
        t.exp_rd = erd; t.exp_rr = err;
        t.ga = ga;  t.exp_g = eg; t.bb = bb; t.exp_b = eb;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (wen1 && waddr1 == a) return wdata1;
        if (wen0 && waddr0 == a) return wdata0;
        return m_mem[a];
    endfunction

    function automatic logic m_ready(input logic [AW-1:0] a);
        if (a == 0) return 1'b1;
        if ((wen1 && waddr1 == a) || (wen0 && waddr0 == a)) return 1'b1;
        return !m_busy[a];
    endfunction

    task automatic m_update();
        if (rst) begin
            for (int i = 0; i < RN; i++) m_mem[i] = '0;
            m_busy = '0;
        end else begin
            if (wen0 && waddr0 != 0) m_mem[waddr0] = wdata0;
            if (wen1 && waddr1 != 0) m_mem[waddr1] = wdata1;
            if (wen0 && waddr0 != 0) m_busy[waddr0] = 1'b0;
            if (wen1 && waddr1 != 0) m_busy[waddr1] = 1'b0;
            if (bset_en && bset_addr != 0) m_busy[bset_addr] = 1'b1;
        end
    endtask

    task automatic check_gpr(input string name);
        int bad;
        bad = -1;
        for (int i = RN - 1; i >= 0; i--) begin
            if (gpr_flat[i*DW +: DW] !== m_mem[i]) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s reg %0d got %0h expected %0h", name, bad,
                     gpr_flat[bad*DW +: DW], m_mem[bad]);
        end
    endtask

    task automatic drive_idle();
        rst = 1'b0; wen0 = 1'b0; wen1 = 1'b0;
        waddr0 = '0; waddr1 = '0; wdata0 = '0; wdata1 = '0;
        bset_en = 1'b0; bset_addr = '0; raddr = '0;
    endtask

    // Entered just after a rising edge with inputs already driven.
    task automatic step_model();
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("rdata%0d", k), rdata[k*DW +: DW], m_read(raddr[k*AW +: AW]));
            check($sformatf("rready%0d", k), rready[k], m_ready(raddr[k*AW +: AW]));
        end
        @(posedge clk);
        m_update();
        #1;
        check("busy", busy, m_busy);
        check_gpr("gpr_flat");
    endtask

    task automatic apply_vec(input vec_t t, input int idx);
        rst = t.rst; wen0 = t.w0; waddr0 = t.a0; wdata0 = t.d0;
        wen1 = t.w1; waddr1 = t.a1; wdata1 = t.d1;
        bset_en = t.bs; bset_addr = t.ba; raddr = {NR{t.ra}};
        @(negedge clk);
        check($sformatf("vec%0d rdata", idx), rdata[0 +: DW], t.exp_rd);
        check($sformatf("vec%0d rdata3", idx), rdata[3*DW +: DW], t.exp_rd);
        check($sformatf("vec%0d rready", idx), rready, {NR{t.exp_rr}});
        @(posedge clk);
        m_update();
        #1;
        check($sformatf("vec%0d gpr r%0d", idx, t.ga), gpr_flat[t.ga*DW +: DW], t.exp_g);
        check($sformatf("vec%0d busy r%0d", idx, t.bb), busy[t.bb], t.exp_b);
    endtask

    function automatic logic [AW-1:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, RN - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    initial begin
        //       rst w0 a0 d0            w1 a1 d1            bs ba ra  exp_rd        rr ga exp_g         bb b
        vecs.push_back(v(1, 0, 0,  0,            0, 0, 0,            0, 0, 0,  0,            1, 5, 0,            0, 0));
        vecs.push_back(v(0, 1, 5,  32'h12345678, 0, 0, 0,            0, 0, 5,  32'h12345678, 1, 5, 32'h12345678, 5, 0));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 5,  32'h12345678, 1, 5, 32'h12345678, 5, 0));
        vecs.push_back(v(0, 1, 7,  32'hAAAA0000, 1, 7, 32'h0000BBBB, 0, 0, 7,  32'h0000BBBB, 1, 7, 32'h0000BBBB, 7, 0));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 7,  32'h0000BBBB, 1, 7, 32'h0000BBBB, 7, 0));
        vecs.push_back(v(0, 1, 0,  32'hFFFFFFFF, 0, 0, 0,            1, 0, 0,  0,            1, 0, 0,            0, 0));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            1, 9, 9,  0,            1, 9, 0,            9, 1));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 9,  0,            0, 9, 0,            9, 1));
        vecs.push_back(v(0, 0, 0,  0,            1, 9, 32'h55,       0, 0, 9,  32'h55,       1, 9, 32'h55,       9, 0));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 9,  32'h55,       1, 9, 32'h55,       9, 0));
        vecs.push_back(v(0, 1, 3,  32'hDEAD0003, 0, 0, 0,            1, 3, 3,  32'hDEAD0003, 1, 3, 32'hDEAD0003, 3, 1));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 3,  32'hDEAD0003, 0, 3, 32'hDEAD0003, 3, 1));
        vecs.push_back(v(1, 1, 4,  32'h1,        0, 0, 0,            1, 4, 4,  32'h1,        1, 4, 0,            4, 0));
        vecs.push_back(v(0, 0, 0,  0,            0, 0, 0,            0, 0, 4,  0,            1, 4, 0,            3, 0));

        for (int i = 0; i < RN; i++) m_mem[i] = '0;
        m_busy = '0;
        drive_idle();
        rst = 1'b1;
        @(posedge clk);
        m_update();
        #1;

        // Reset state: all reads zero, all ports ready, no busy bits.
        rst = 1'b0;
        raddr = {5'd31, 5'd3, 5'd2, 5'd1};
        @(negedge clk);
        check("reset rdata", rdata, '0);
        check("reset rready", rready, 4'hF);
        check("reset busy", busy, '0);
        @(posedge clk);
        m_update();
        #1;
        check_gpr("reset gpr_flat");

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Reset with a same-cycle write and bset left nothing behind.
        check("post-rst busy", busy, '0);
        check("post-rst r3", gpr_flat[3*DW +: DW], '0);
        check("post-rst r7", gpr_flat[7*DW +: DW], '0);

        // Four read ports on four distinct registers.
        drive_idle();
        wen0 = 1'b1; waddr0 = 5'd1; wdata0 = 32'h11111111;
        wen1 = 1'b1; waddr1 = 5'd2; wdata1 = 32'h22222222;
        step_model();
        waddr0 = 5'd3; wdata0 = 32'h33333333;
        waddr1 = 5'd4; wdata1 = 32'h44444444;
        bset_en = 1'b1; bset_addr = 5'd2;
        step_model();
        drive_idle();
        raddr = {5'd4, 5'd3, 5'd2, 5'd1};
        @(negedge clk);
        check("distinct rd0", rdata[0*DW +: DW], 32'h11111111);
        check("distinct rd1", rdata[1*DW +: DW], 32'h22222222);
        check("distinct rd2", rdata[2*DW +: DW], 32'h33333333);
        check("distinct rd3", rdata[3*DW +: DW], 32'h44444444);
        check("distinct rready", rready, 4'b1101);
        @(posedge clk);
        m_update();
        #1;

        // Randomized traffic with concentrated addresses to force collisions.
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(0, 39) == 0);
            wen0      = $urandom_range(0, 1) == 1;
            wen1      = $urandom_range(0, 1) == 1;
            waddr0    = pick_addr();
            waddr1    = pick_addr();
            wdata0    = $urandom;
            wdata1    = $urandom;
            bset_en   = $urandom_range(0, 1) == 1;
            bset_addr = pick_addr();
            for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = pick_addr();
            step_model();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
